muldiv_unit: RTL and testbench

- Iterative 32-bit multiply/divide unit for the multi-cycle datapath.
- Operates alongside the ALU. Its hi/lo results feed data inputs of the 16-way 32-bit result-select mux ahead of register writeback.
- The control FSM starts an operation, stalls on busy, and steers the mux to hi or lo once done pulses.
- One result bit per cycle: shift-add for multiply, restoring for divide.

---
 rtl/muldiv_if.sv | 24 ++
 rtl/muldiv_unit.sv | 140 ++++++++++++++
 tb/tb_muldiv_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Handshake and result bus between the control FSM and the iterative multiply/divide unit.
interface muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide: one result bit per clock, shift-add multiply and restoring divide
// on operand magnitudes, with sign correction applied in a final FIX cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             div_op;
  logic             neg_res;
  logic             neg_rem;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic             load_c, step_c, fix_c;
  logic             sign_a_c, sign_b_c;
  logic [WIDTH-1:0] mag_a_c, mag_b_c;
  logic [WIDTH:0]   add_sum_c, shl_c, sub_c;
  logic             ge_c;
  logic [PW-1:0]    prod_c, prod_fix_c;
  logic [WIDTH-1:0] quo_fix_c, rem_fix_c;
  logic             dbz_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CALC;
      CALC:    if (cnt == CW'(1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state datapath strobes
  always_comb begin
    load_c = 1'b0;
    step_c = 1'b0;
    fix_c  = 1'b0;
    case (state)
      IDLE:    load_c = bus.start;
      CALC:    step_c = 1'b1;
      FIX:     fix_c  = 1'b1;
      default: ;
    endcase
  end

  // Operand magnitudes; op[0] selects the signed variants
  always_comb begin
    sign_a_c = bus.op[0] & bus.a[WIDTH-1];
    sign_b_c = bus.op[0] & bus.b[WIDTH-1];
    mag_a_c  = sign_a_c ? (~bus.a + WIDTH'(1)) : bus.a;
    mag_b_c  = sign_b_c ? (~bus.b + WIDTH'(1)) : bus.b;
  end

  // One iteration of shift-add (multiply) and restoring subtract (divide)
  always_comb begin
    add_sum_c  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    shl_c      = {acc_hi, acc_lo[WIDTH-1]};
    ge_c       = shl_c >= {1'b0, opb};
    sub_c      = shl_c - {1'b0, opb};
    prod_c     = {acc_hi, acc_lo};
    prod_fix_c = neg_res ? (~prod_c + PW'(1)) : prod_c;
    quo_fix_c  = neg_res ? (~acc_lo + WIDTH'(1)) : acc_lo;
    rem_fix_c  = neg_rem ? (~acc_hi + WIDTH'(1)) : acc_hi;
    dbz_c      = div_op & (opb == '0);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt             <= '0;
      div_op          <= 1'b0;
      neg_res         <= 1'b0;
      neg_rem         <= 1'b0;
      a_raw           <= '0;
      opb             <= '0;
      acc_hi          <= '0;
      acc_lo          <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.hi          <= '0;
      bus.lo          <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (load_c) begin
        div_op   <= bus.op[1];
        neg_res  <= sign_a_c ^ sign_b_c;
        neg_rem  <= sign_a_c;
        a_raw    <= bus.a;
        acc_hi   <= '0;
        acc_lo   <= bus.op[1] ? mag_a_c : mag_b_c;
        opb      <= bus.op[1] ? mag_b_c : mag_a_c;
        cnt      <= CW'(WIDTH);
        bus.busy <= 1'b1;
      end else if (step_c) begin
        cnt <= cnt - CW'(1);
        if (div_op) begin
          acc_hi <= ge_c ? sub_c[WIDTH-1:0] : shl_c[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], ge_c};
        end else begin
          acc_hi <= add_sum_c[WIDTH:1];
          acc_lo <= {add_sum_c[0], acc_lo[WIDTH-1:1]};
        end
      end else if (fix_c) begin
        bus.busy        <= 1'b0;
        bus.done        <= 1'b1;
        bus.div_by_zero <= dbz_c;
        // A zero divisor returns all-ones quotient and the untouched dividend
        if (dbz_c) begin
          bus.hi <= a_raw;
          bus.lo <= '1;
        end else if (div_op) begin
          bus.hi <= rem_fix_c;
          bus.lo <= quo_fix_c;
        end else begin
          bus.hi <= prod_fix_c[PW-1:WIDTH];
          bus.lo <= prod_fix_c[WIDTH-1:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: hand-computed multiply/divide results,
// latency, start-while-busy, back-to-back start and mid-operation reset.
module tb_muldiv_unit;
  localparam int unsigned W = 32;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;
  int   done_seen;
  logic [W-1:0] prev_hi;
  logic [W-1:0] prev_lo;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; presents one start for exactly one rising edge, then scrambles inputs
  task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.op    = 2'($urandom);
  endtask

  // Counts busy samples until done, checking outputs hold their previous result meanwhile
  task automatic wait_done(input string tag, output int busy_cnt);
    int guard;
    guard    = 0;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && guard < 200) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (guard == 20) chk({tag, "_hold"}, {bus.hi, bus.lo}, {prev_hi, prev_lo});
      guard++;
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, 64'(bus.done), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input logic edbz);
    int n;
    start_op(op, a, b);
    wait_done(tag, n);
    chk({tag, "_busy_cycles"}, 64'(n), 64'd33);
    chk({tag, "_hi"}, 64'(bus.hi), 64'(ehi));
    chk({tag, "_lo"}, 64'(bus.lo), 64'(elo));
    chk({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(edbz));
    chk({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    prev_hi = ehi;
    prev_lo = elo;
    @(negedge clk);
    chk({tag, "_done_cleared"}, 64'(bus.done), 64'd0);
    chk({tag, "_held"}, {bus.hi, bus.lo}, {ehi, elo});
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    prev_hi   = '0;
    prev_lo   = '0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("rst_dbz", 64'(bus.div_by_zero), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_neg",  2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("div_neg",   2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_pos_neg", 2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    run_op("div_ovf",   2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op("divu_zero", 2'b10, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
    run_op("divu_100_7", 2'b10, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0);
    run_op("div_zero_s", 2'b11, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
    run_op("mult_pos",  2'b01, 32'h0000_0006, 32'h0000_0007, 32'h0000_0000, 32'h0000_002A, 1'b0);

    // A start while busy must be ignored
    start_op(2'b10, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.a     = 32'd3;
    bus.b     = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("ign", cyc);
    chk("ign_hi", 64'(bus.hi), 64'd2);
    chk("ign_lo", 64'(bus.lo), 64'd14);
    prev_hi = 32'd2;
    prev_lo = 32'd14;

    // Start accepted in the done cycle
    start_op(2'b00, 32'd3, 32'd3);
    wait_done("b2b", cyc);
    chk("b2b_busy_cycles", 64'(cyc), 64'd33);
    chk("b2b_hi", 64'(bus.hi), 64'd0);
    chk("b2b_lo", 64'(bus.lo), 64'd9);
    prev_hi = 32'd0;
    prev_lo = 32'd9;
    @(negedge clk);
    chk("b2b_done_cleared", 64'(bus.done), 64'd0);

    // Reset during CALC aborts without a done pulse and clears results
    start_op(2'b00, 32'd5, 32'd5);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    chk("abort_no_done", 64'(done_seen), 64'd0);
    prev_hi = '0;
    prev_lo = '0;
    run_op("after_rst", 2'b00, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
